// File: rtl/op_exec_pkg.sv
// Shared definitions for op_exec: opcode values, halt word, FSM state encoding and multiply length.
package op_exec_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
    localparam int unsigned MUL_CYCLES  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StMul,
        StWrite,
        StHalt
    } state_e;

endpackage

// File: rtl/op_exec_if.sv
// Request/result bundle between a controller (master) and the op_exec engine (slave).
interface op_exec_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] opcode;
    logic [ADDR_W-1:0] dest_addr;
    logic              busy;
    logic              done;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              halted;
    logic              illegal;

    modport master (
        output start, op_a, op_b, opcode, dest_addr,
        input  busy, done, ram_we, ram_addr, ram_din, halted, illegal
    );

    modport slave (
        input  start, op_a, op_b, opcode, dest_addr,
        output busy, done, ram_we, ram_addr, ram_din, halted, illegal
    );

endinterface

// File: rtl/seq_mul32.sv
// Shift-add multiplier, one multiplier bit per cycle, low 32 bits of the product.
module seq_mul32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product,
    output logic        done
);
    import op_exec_pkg::*;

    logic [31:0] r_acc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  r_cnt;
    logic        r_run;
    logic [31:0] w_addend;

    // product already includes the current step, so the final value is ready with done
    assign w_addend = r_b[0] ? r_a : 32'd0;
    assign product  = r_acc + w_addend;
    assign done     = r_run && (r_cnt == 6'(MUL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 32'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_cnt <= 6'd0;
            r_run <= 1'b0;
        end else if (load) begin
            r_acc <= 32'd0;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= 6'd0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= product;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            if (done) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/op_exec.sv
// Single-operation execute engine: ALU or sequential multiply, result written to RAM.
// Define OP_EXEC_MUL_EN to enable the 32-cycle multiply; otherwise opcode 7 is illegal.
module op_exec #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    op_exec_if.slave    bus
);
    import op_exec_pkg::*;

    state_e            r_state;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [2:0]        r_opc;
    logic [ADDR_W-1:0] r_dest;
    logic              r_busy;
    logic              r_done;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_halted;
    logic              r_illegal;

    logic              w_is_halt;
    logic              w_is_mul;
    logic [DATA_W-1:0] w_alu;

    assign w_is_halt = (bus.opcode == HALT_OPCODE);
    assign w_is_mul  = (bus.opcode[2:0] == OP_MUL);

    always_comb begin
        w_alu = '0;
        case (r_opc)
            OP_ADD:  w_alu = r_op_a + r_op_b;
            OP_SUB:  w_alu = r_op_a - r_op_b;
            OP_AND:  w_alu = r_op_a & r_op_b;
            OP_OR:   w_alu = r_op_a | r_op_b;
            OP_XOR:  w_alu = r_op_a ^ r_op_b;
            OP_SLL:  w_alu = r_op_a << r_op_b[4:0];
            OP_SRL:  w_alu = r_op_a >> r_op_b[4:0];
            default: w_alu = '0;
        endcase
    end

`ifdef OP_EXEC_MUL_EN
    logic        w_mul_load;
    logic [31:0] w_mul_prod;
    logic        w_mul_done;

    assign w_mul_load = (r_state == StIdle) && bus.start && !w_is_halt && w_is_mul;

    seq_mul32 u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (w_mul_load),
        .a       (bus.op_a),
        .b       (bus.op_b),
        .product (w_mul_prod),
        .done    (w_mul_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_opc      <= 3'd0;
            r_dest     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_op_a <= bus.op_a;
                        r_op_b <= bus.op_b;
                        r_opc  <= bus.opcode[2:0];
                        r_dest <= bus.dest_addr;
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= StHalt;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= StCalc;
`ifdef OP_EXEC_MUL_EN
                            if (w_is_mul) r_state <= StMul;
`else
                            if (w_is_mul) r_illegal <= 1'b1;
`endif
                        end
                    end
                end
                // Write strobes are loaded one cycle early so they are high exactly in WRITE
                StCalc: begin
                    r_ram_we   <= 1'b1;
                    r_done     <= 1'b1;
                    r_ram_addr <= r_dest;
                    r_ram_din  <= w_alu;
                    r_state    <= StWrite;
                end
`ifdef OP_EXEC_MUL_EN
                StMul: begin
                    if (w_mul_done) begin
                        r_ram_we   <= 1'b1;
                        r_done     <= 1'b1;
                        r_ram_addr <= r_dest;
                        r_ram_din  <= w_mul_prod;
                        r_state    <= StWrite;
                    end
                end
`endif
                StWrite: begin
                    r_ram_we <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
                StHalt: begin
                    r_state <= StHalt;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_din  = r_ram_din;
    assign bus.halted   = r_halted;
    assign bus.illegal  = r_illegal;

endmodule
